// File: rtl/boot_loader_if.sv
// Byte-stream input and BRAM write/core-control bundle between the UART side and the boot loader.
interface boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_dat;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] i_w_addr;
    logic [31:0]           i_w_dat;
    logic                  i_w_enb;
    logic [ADDR_WIDTH-1:0] d_w_addr;
    logic [31:0]           d_w_dat;
    logic                  d_w_enb;
    logic                  pc_stall;
    logic                  i_r_enb;
    logic                  d_bram_init_done;
    logic                  busy;
    logic                  error;

    modport master (
        input  rx_dat, rx_valid,
        output rx_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
        output pc_stall, i_r_enb, d_bram_init_done, busy, error
    );

    modport slave (
        output rx_dat, rx_valid,
        input  rx_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
        input  pc_stall, i_r_enb, d_bram_init_done, busy, error
    );
endinterface

// File: rtl/boot_loader.sv
// Assembles little-endian words from a command/segment byte stream into instruction or data BRAM,
// then releases the core on the run command.
module boot_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 256
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus
);
    localparam logic [7:0] CMD_INSTR = 8'hA5;
    localparam logic [7:0] CMD_DATA  = 8'h5A;
    localparam logic [7:0] CMD_RUN   = 8'hC3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  accept_s;
    logic                  word_done_s;
    logic [15:0]           count_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [7:0]            cnt_lo_r;
    logic [8:0]            n_words_r;
    logic [8:0]            word_cnt_r;
    logic [1:0]            byte_idx_r;
    logic [23:0]           asm_r;
    logic                  seg_data_r;

    assign bus.rx_ready = (state_r == ST_IDLE) || (state_r == ST_CNT_LO) ||
                          (state_r == ST_CNT_HI) || (state_r == ST_DATA);
    assign accept_s     = bus.rx_valid & bus.rx_ready;
    assign word_done_s  = accept_s && (state_r == ST_DATA) && (byte_idx_r == 2'd3);
    assign count_s      = {bus.rx_dat, cnt_lo_r};
    assign addr_s       = ADDR_WIDTH'({word_cnt_r, 2'b00});

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if ((bus.rx_dat == CMD_INSTR) || (bus.rx_dat == CMD_DATA)) begin
                    state_s = ST_CNT_LO;
                end else if (bus.rx_dat == CMD_RUN) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            ST_CNT_LO: begin
                if (accept_s) begin
                    state_s = ST_CNT_HI;
                end else begin
                    state_s = ST_CNT_LO;
                end
            end
            ST_CNT_HI: begin
                if (!accept_s) begin
                    state_s = ST_CNT_HI;
                end else if (count_s == 16'd0) begin
                    state_s = ST_IDLE;
                end else if (count_s > 16'(MAX_WORDS)) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                // word_cnt_r was already advanced on the accept edge of the 4th byte
                if (word_cnt_r == n_words_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_RUN:   state_s = ST_RUN;
            ST_ERROR: state_s = ST_ERROR;
            default:  state_s = ST_ERROR;
        endcase
    end

    // Segment bookkeeping, word assembly, BRAM write ports and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_lo_r             <= 8'd0;
            n_words_r            <= 9'd0;
            word_cnt_r           <= 9'd0;
            byte_idx_r           <= 2'd0;
            asm_r                <= 24'd0;
            seg_data_r           <= 1'b0;
            bus.i_w_addr         <= '0;
            bus.i_w_dat          <= 32'd0;
            bus.i_w_enb          <= 1'b0;
            bus.d_w_addr         <= '0;
            bus.d_w_dat          <= 32'd0;
            bus.d_w_enb          <= 1'b0;
            bus.pc_stall         <= 1'b1;
            bus.i_r_enb          <= 1'b0;
            bus.d_bram_init_done <= 1'b0;
            bus.busy             <= 1'b0;
            bus.error            <= 1'b0;
        end else begin
            bus.i_w_enb <= 1'b0;
            bus.d_w_enb <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    ST_IDLE:   seg_data_r <= (bus.rx_dat == CMD_DATA);
                    ST_CNT_LO: cnt_lo_r   <= bus.rx_dat;
                    ST_CNT_HI: begin
                        n_words_r  <= count_s[8:0];
                        word_cnt_r <= 9'd0;
                        byte_idx_r <= 2'd0;
                    end
                    ST_DATA: begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        asm_r      <= {bus.rx_dat, asm_r[23:8]};
                        if (byte_idx_r == 2'd3) begin
                            word_cnt_r <= word_cnt_r + 9'd1;
                            if (seg_data_r) begin
                                bus.d_w_addr <= addr_s;
                                bus.d_w_dat  <= {bus.rx_dat, asm_r};
                                bus.d_w_enb  <= 1'b1;
                            end else begin
                                bus.i_w_addr <= addr_s;
                                bus.i_w_dat  <= {bus.rx_dat, asm_r};
                                bus.i_w_enb  <= 1'b1;
                            end
                        end
                    end
                    default: cnt_lo_r <= cnt_lo_r;
                endcase
            end
            bus.busy             <= (state_s == ST_CNT_LO) || (state_s == ST_CNT_HI) ||
                                    (state_s == ST_DATA) || (state_s == ST_WRITE);
            bus.pc_stall         <= (state_s != ST_RUN);
            bus.i_r_enb          <= (state_s == ST_RUN);
            bus.d_bram_init_done <= (state_s == ST_RUN);
            bus.error            <= (state_s == ST_ERROR);
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Randomized-gap stimulus for boot_loader, checked every cycle against a byte-history protocol model.
module tb_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    boot_loader_if #(.ADDR_WIDTH(10)) bus ();
    boot_loader #(.ADDR_WIDTH(10), .MAX_WORDS(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { bit is_d; logic [9:0] addr; logic [31:0] dat; } wr_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] hist[$];
    wr_t m_wr[$];
    bit m_run, m_err, m_inseg, m_lastword;
    bit pend = 0, acc_last = 0, prev_stb = 0, first_i_set = 0;
    logic [7:0] pend_byte = 8'd0;
    int cnt_i = 0, cnt_d = 0;
    logic [31:0] first_i_dat = 32'd0;
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reinterpret the whole accepted-byte history since reset as commands and segments
    task automatic model_eval();
        int p, n, last_end;
        bit stop;
        logic [7:0] c;
        wr_t w;
        p = 0; last_end = -1; stop = 0;
        m_run = 0; m_err = 0; m_inseg = 0;
        m_wr.delete();
        while (!stop && p < hist.size()) begin
            c = hist[p]; p++;
            if (c == 8'hC3) begin
                m_run = 1; stop = 1;
            end else if (c == 8'hA5 || c == 8'h5A) begin
                if (p + 2 > hist.size()) begin
                    m_inseg = 1; stop = 1;
                end else begin
                    n = int'({hist[p+1], hist[p]}); p += 2;
                    if (n > 256) begin
                        m_err = 1; stop = 1;
                    end else begin
                        for (int k = 0; k < n && !stop; k++) begin
                            if (p + 4 > hist.size()) begin
                                m_inseg = 1; stop = 1;
                            end else begin
                                w.is_d = (c == 8'h5A);
                                w.addr = 10'(k * 4);
                                w.dat  = {hist[p+3], hist[p+2], hist[p+1], hist[p]};
                                m_wr.push_back(w);
                                p += 4;
                                last_end = p;
                            end
                        end
                    end
                end
            end else begin
                m_err = 1; stop = 1;
            end
        end
        m_lastword = (last_end == hist.size());
    endtask

    // Per-cycle compare of every DUT output against the model, sampled on the falling edge
    always @(negedge clk) begin
        bit wend, stb;
        wr_t li, ld;
        if (!rst) begin
            hist.delete(); acc_last = 0; cnt_i = 0; cnt_d = 0; prev_stb = 0; first_i_set = 0;
        end else if (pend) begin
            hist.push_back(pend_byte); acc_last = 1;
        end else begin
            acc_last = 0;
        end
        model_eval();
        wend = acc_last && m_lastword;
        li = '{0, 10'd0, 32'd0};
        ld = '{1, 10'd0, 32'd0};
        foreach (m_wr[i]) begin
            if (m_wr[i].is_d) ld = m_wr[i]; else li = m_wr[i];
        end
        chk("rx_ready", bus.rx_ready, !m_run && !m_err && !wend);
        chk("busy", bus.busy, m_inseg || wend);
        chk("pc_stall", bus.pc_stall, !m_run);
        chk("i_r_enb", bus.i_r_enb, m_run);
        chk("d_bram_init_done", bus.d_bram_init_done, m_run);
        chk("error", bus.error, m_err);
        chk("i_w_enb", bus.i_w_enb, wend && !m_wr[$].is_d);
        chk("d_w_enb", bus.d_w_enb, wend && m_wr[$].is_d);
        chk("i_w_addr", bus.i_w_addr, li.addr);
        chk("i_w_dat", bus.i_w_dat, li.dat);
        chk("d_w_addr", bus.d_w_addr, ld.addr);
        chk("d_w_dat", bus.d_w_dat, ld.dat);
        stb = bus.i_w_enb || bus.d_w_enb;
        if (stb) chk("strobe_spacing", prev_stb, 1'b0);
        prev_stb = stb;
        if (bus.i_w_enb === 1'b1) begin
            cnt_i++;
            if (!first_i_set) begin first_i_dat = bus.i_w_dat; first_i_set = 1; end
        end
        if (bus.d_w_enb === 1'b1) cnt_d++;
        pend = rst && bus.rx_valid && bus.rx_ready;
        pend_byte = bus.rx_dat;
    end

    // Present one byte (after an idle gap) and hold it until accepted or a cycle budget runs out
    task automatic send(input logic [7:0] b, input int gap, input bit must, output bit acc);
        int waited = 0;
        acc = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b1;
        bus.rx_dat   = b;
        while (!acc && waited < 12) begin
            acc = bus.rx_ready && rst;
            @(posedge clk); #1;
            waited++;
        end
        bus.rx_valid = 1'b0;
        if (must) chk("byte_accepted", acc, 1'b1);
    endtask

    task automatic load_seg(input logic [7:0] cmd, input int n, input int maxgap);
        bit acc;
        logic [31:0] w;
        send(cmd, $urandom_range(0, maxgap), 1'b1, acc);
        send(8'(n), $urandom_range(0, maxgap), 1'b1, acc);
        send(8'(n >> 8), $urandom_range(0, maxgap), 1'b1, acc);
        if (n <= 256) begin
            for (int k = 0; k < n; k++) begin
                w = (k < wq.size()) ? wq[k] : $urandom;
                for (int b = 0; b < 4; b++) send(w[8*b +: 8], $urandom_range(0, maxgap), 1'b1, acc);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_pc_stall", bus.pc_stall, 1'b1);
        chk("reset_rx_ready", bus.rx_ready, 1'b1);
        chk("reset_busy", bus.busy, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bit acc;
        bus.rx_valid = 1'b0;
        bus.rx_dat   = 8'd0;
        do_reset();

        // data N=2, instruction N=5, then run
        wq = '{32'h00000003, 32'h00000002};
        load_seg(8'h5A, 2, 2);
        wq = '{32'h407302B3};
        load_seg(8'hA5, 5, 3);
        send(8'hC3, 1, 1'b1, acc);
        repeat (3) begin @(posedge clk); #1; end
        chk("plan_d_strobes", cnt_d, 2);
        chk("plan_i_strobes", cnt_i, 5);
        chk("plan_d_last_addr", bus.d_w_addr, 10'h004);
        chk("plan_d_last_dat", bus.d_w_dat, 32'h00000002);
        chk("plan_i_last_addr", bus.i_w_addr, 10'h010);
        chk("plan_i_first_dat", first_i_dat, 32'h407302B3);
        chk("plan_run_pc_stall", bus.pc_stall, 1'b0);
        chk("plan_run_i_r_enb", bus.i_r_enb, 1'b1);
        chk("plan_run_init_done", bus.d_bram_init_done, 1'b1);

        // bad command, then a run that must be ignored
        do_reset();
        send(8'h00, 0, 1'b1, acc);
        repeat (2) begin @(posedge clk); #1; end
        chk("err_error", bus.error, 1'b1);
        chk("err_rx_ready", bus.rx_ready, 1'b0);
        send(8'hC3, 0, 1'b0, acc);
        chk("err_run_ignored", acc, 1'b0);
        chk("err_pc_stall", bus.pc_stall, 1'b1);

        // zero-length segment, then oversize count
        do_reset();
        load_seg(8'hA5, 0, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("n0_busy", bus.busy, 1'b0);
        chk("n0_strobes", cnt_i + cnt_d, 0);
        chk("n0_ready", bus.rx_ready, 1'b1);
        load_seg(8'h5A, 257, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("n257_error", bus.error, 1'b1);

        // 3-word segment with random 0-7 cycle gaps
        do_reset();
        wq.delete();
        load_seg(8'h5A, 3, 7);
        repeat (3) begin @(posedge clk); #1; end
        chk("gap_d_strobes", cnt_d, 3);
        chk("gap_d_last_addr", bus.d_w_addr, 10'h008);

        // reset mid-word, then reload from address 0
        do_reset();
        send(8'hA5, 0, 1'b1, acc);
        send(8'h04, 0, 1'b1, acc);
        send(8'h00, 0, 1'b1, acc);
        send(8'h11, 0, 1'b1, acc);
        send(8'h22, 2, 1'b1, acc);
        rst = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_pc_stall", bus.pc_stall, 1'b1);
        chk("abort_i_w_enb", bus.i_w_enb, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        wq = '{32'hDEADBEEF};
        load_seg(8'hA5, 4, 2);
        repeat (3) begin @(posedge clk); #1; end
        chk("reload_i_strobes", cnt_i, 4);
        chk("reload_first_dat", first_i_dat, 32'hDEADBEEF);
        chk("reload_last_addr", bus.i_w_addr, 10'h00C);

        // random segment mixes, each ending in run
        wq.delete();
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int s = 0; s < 3; s++) load_seg(($urandom_range(0, 1) == 0) ? 8'hA5 : 8'h5A, $urandom_range(0, 4), 3);
            send(8'hC3, $urandom_range(0, 3), 1'b1, acc);
            repeat (2) begin @(posedge clk); #1; end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
